bplserial: RTL and testbench
============================

# bplserial

Parametrised bitplane parallel-to-serial engine for the Denise video path; the successor of the OCS bitplane shifter. Accepts BPLxDAT writes of 16/32/64-bit fetches for up to 8 planes and serialises them at lores, hires or super-hires rate from a single 28 MHz pixel clock, with no double-pumped logic clock. Per-playfield scroll is in super-hires (quarter-lores-pixel) steps up to 255. Output feeds the playfield/priority logic unchanged.

## Interface
- PLANES, 8: number of bitplanes, 1..8.
- FETCH, 1: fetch width in 16-bit words, one of 1, 2, 4; W = 16*FETCH.
- clk  in  1  28.37516 MHz super-hires pixel clock; all logic on posedge.
- _reset  in  1  asynchronous, active-low reset.
- reg_wr  in  1  one-cycle register write strobe.
- regaddress  in  8  register address [8:1].
- datain  in  W  bus data; BPLCON1 uses [15:0].
- hires  in  1  hires mode (2 clk per pixel).
- shres  in  1  super-hires mode (1 clk per pixel); overrides hires.
- bpldata  out  PLANES  serial pixel data, bit n-1 = plane n.

## Operation
- Registers, written only when reg_wr=1 and regaddress matches:
  - BPLCON1 0x102, 16 bits.
  - BPLnDAT 0x110+2*(n-1) for n=1..PLANES; addresses for planes > PLANES are ignored.
- Scroll delays, in super-hires pixels, 8 bits each:
  - Odd planes (1,3,5,7): D1 = {bplcon1[11:10], bplcon1[3:0], bplcon1[9:8]}.
  - Even planes: D2 = {bplcon1[15:14], bplcon1[7:4], bplcon1[13:12]}.
- Buffers: planes 2..PLANES each hold a W-bit buffer.
- Load: a write to BPL1DAT is the load event. In that cycle:
  - Every plane's main shifter (W bits) loads: plane 1 from datain, the others from their buffers.
  - All buffers clear to 0.
  - The phase counter ph[1:0] clears to 0.
- Shift enable: ph increments every clk (wraps 3->0). se = 1 when:
  - shres=1;
  - else hires=1 and ph[0]=1;
  - else (lores) ph=3.
- Main shifter:
  - Shifts left, inserting 0, when se=1 and no load.
  - The MSB is the current pixel, so bit W-1 comes out first.
  - Once exhausted with no new load, output is 0.
- Delay line per plane: 255-bit shift register. Every clk: dl <= {dl[253:0], msb}.
- Output: plane output = msb if D=0, else dl[D-1], using D1 or D2 for the plane. bpldata is combinational from registers.
- Mode inputs are sampled every clk. A mid-word mode change takes effect on the next se evaluation; the shifter contents are kept.
- A BPLCON1 write retargets the tap the next cycle. Pixels may repeat or skip at that instant; this is accepted behaviour, with no resynchronisation.
- A load arriving before the shifter is exhausted overwrites the remaining bits.

## Timing
- Reset (async assert, sync release): all of the following are 0, so bpldata = 0:
  - bplcon1, buffers, shifters, delay lines, ph.
- Load at edge k: bit W-1 is visible on bpldata from after edge k (latency 1 clk for D=0).
- Each pixel is held:
  - 4 clk in lores: pixel i spans cycles k+4i .. k+4i+3.
  - 2 clk in hires.
  - 1 clk in shres.
- Delay D shifts the output sequence by exactly D clk.
- Shifter empties after 16*FETCH*{4,2,1} clk; zeros follow.
- Register write to visible effect: 1 clk.
- Reset mid-line: immediate zeroing, including delay-line contents.

## Test plan
- FETCH=1, lores, D1=D2=0: buffer BPL2DAT=0x0000, write BPL1DAT=0x8001 -> bpldata[0]=1 for 4 clk after load, 0 for 56 clk, 1 for 4 clk, then 0. bpldata[1]=0 throughout.
- Hires, FETCH=2, plane 1 = 0xAAAAAAAA -> bpldata[0] alternates 1,1,0,0,… with 2-clk pixels for 64 clk, then 0.
- Shres, BPLCON1=0x0300 (D1=3, D2=0), plane 1 = plane 2 = 0x8000 -> bpldata[1] high in cycle 1 after load; bpldata[0] high in cycle 4.
- Lores, BPLCON1=0x000F (D1=60): verify a 60-clk shift versus plane 2. Then write BPLCON1=0 mid-word -> the tap moves the next cycle.
- PLANES=8: write BPL8DAT=0xFFFF then BPL1DAT=0 -> bpldata=0x80 for 64 clk. A second BPL1DAT load without a BPL8DAT rewrite -> plane 8 outputs 0 (buffer cleared).
- Assert _reset mid-word -> bpldata=0 within the same cycle. After release, with no load, output stays 0 for ≥256 clk.

Source files
------------

// File: rtl/bplserial_if.sv
// bplserial_if: register-write bus, mode controls and serial pixel output of the bitplane serialiser.
interface bplserial_if #(
   parameter int PLANES = 8,
   parameter int FETCH  = 1
);
   logic                  reg_wr_i;
   logic [7:0]            regaddress_i;
   logic [16*FETCH-1:0]   datain_i;
   logic                  hires_i;
   logic                  shres_i;
   logic [PLANES-1:0]     bpldata_o;

   modport master (output reg_wr_i, regaddress_i, datain_i, hires_i, shres_i, input bpldata_o);
   modport slave  (input reg_wr_i, regaddress_i, datain_i, hires_i, shres_i, output bpldata_o);
endinterface

// File: rtl/bplserial.sv
// bplserial: bitplane parallel-to-serial shifter with per-playfield super-hires scroll delay lines.
module bplserial #(
   parameter int PLANES = 8,
   parameter int FETCH  = 1
) (
   input logic        clk,
   input logic        rst_n,
   bplserial_if.slave bus
);
   localparam int W = 16 * FETCH;

   logic [15:0]       bplcon1_q, bplcon1_d;
   logic [1:0]        ph_q, ph_d;
   logic              ld, se;
   logic [7:0]        d1, d2;
   logic [PLANES-1:0] px;

   // Register addresses are word addresses: 0x102>>1 = 0x81, 0x110>>1 = 0x88.
   always_comb begin
      ld        = bus.reg_wr_i && bus.regaddress_i == 8'h88;
      se        = bus.shres_i || (bus.hires_i ? ph_q[0] : &ph_q);
      ph_d      = ld ? 2'd0 : ph_q + 2'd1;
      bplcon1_d = (bus.reg_wr_i && bus.regaddress_i == 8'h81) ? bus.datain_i[15:0] : bplcon1_q;
      d1        = {bplcon1_q[11:10], bplcon1_q[3:0], bplcon1_q[9:8]};
      d2        = {bplcon1_q[15:14], bplcon1_q[7:4], bplcon1_q[13:12]};
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bplcon1_q <= '0;
         ph_q      <= '0;
      end else begin
         bplcon1_q <= bplcon1_d;
         ph_q      <= ph_d;
      end

   for (genvar i = 0; i < PLANES; i++) begin : g_pl
      logic [W-1:0] sh_q, sh_d, src;
      logic [254:0] dl_q;
      logic [7:0]   dly;
      if (i == 0) begin : g_p1
         assign src = bus.datain_i;
      end else begin : g_pn
         logic [W-1:0] buf_q, buf_d;
         always_comb
            buf_d = ld ? '0 : (bus.reg_wr_i && bus.regaddress_i == 8'(8'h88 + i)) ? bus.datain_i : buf_q;
         always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) buf_q <= '0;
            else buf_q <= buf_d;
         assign src = buf_q;
      end
      always_comb begin
         sh_d  = ld ? src : se ? {sh_q[W-2:0], 1'b0} : sh_q;
         dly   = (i % 2 == 1) ? d2 : d1;
         px[i] = (dly == 8'd0) ? sh_q[W-1] : dl_q[dly-8'd1];
      end
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) begin
            sh_q <= '0;
            dl_q <= '0;
         end else begin
            sh_q <= sh_d;
            dl_q <= {dl_q[253:0], sh_q[W-1]};
         end
   end

   assign bus.bpldata_o = px;
endmodule

// File: tb/tb_bplserial.sv
// tb_bplserial: directed checks of the bitplane serialiser, one 8-plane 16-bit and one 2-plane 32-bit instance.
module tb_bplserial;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   bplserial_if #(.PLANES(8), .FETCH(1)) ifa ();
   bplserial_if #(.PLANES(2), .FETCH(2)) ifb ();

   bplserial #(.PLANES(8), .FETCH(1)) u_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   bplserial #(.PLANES(2), .FETCH(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mode(input logic h, input logic s);
      ifa.hires_i = h; ifb.hires_i = h;
      ifa.shres_i = s; ifb.shres_i = s;
   endtask

   // Leaves the bench 1 time unit after the edge that performed the write.
   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      ifa.reg_wr_i = 1'b1; ifb.reg_wr_i = 1'b1;
      ifa.regaddress_i = a; ifb.regaddress_i = a;
      ifa.datain_i = d[15:0]; ifb.datain_i = d;
      step();
      ifa.reg_wr_i = 1'b0; ifb.reg_wr_i = 1'b0;
   endtask

   initial begin
      logic [7:0] e;
      ifa.reg_wr_i = 1'b0; ifb.reg_wr_i = 1'b0;
      ifa.regaddress_i = '0; ifb.regaddress_i = '0;
      ifa.datain_i = '0; ifb.datain_i = '0;
      mode(1'b0, 1'b0);
      step();
      step();
      chk("reset_a", ifa.bpldata_o, 0);
      chk("reset_b", ifb.bpldata_o, 0);
      rst_n = 1'b1;
      step();

      // lores, 0x8001 on plane 1, plane 2 buffer empty
      wr(8'h89, 32'h0);
      wr(8'h88, 32'h8001);
      for (int c = 0; c < 70; c++) begin
         chk($sformatf("lores_c%0d", c), ifa.bpldata_o, (c < 4 || (c >= 60 && c < 64)) ? 1 : 0);
         step();
      end

      // hires, 32-bit fetch of 0xAAAAAAAA
      mode(1'b1, 1'b0);
      wr(8'h88, 32'hAAAA_AAAA);
      for (int c = 0; c < 70; c++) begin
         chk($sformatf("hires_c%0d", c), ifb.bpldata_o, (c < 64 && (c / 2) % 2 == 0) ? 1 : 0);
         step();
      end

      // shres with D1=3, D2=0
      mode(1'b0, 1'b1);
      wr(8'h81, 32'h0300);
      wr(8'h89, 32'h8000);
      wr(8'h88, 32'h8000);
      for (int c = 0; c < 8; c++) begin
         e = (c == 0 ? 8'h02 : 8'h00) | (c == 3 ? 8'h01 : 8'h00);
         chk($sformatf("shres_c%0d", c), ifa.bpldata_o, e);
         step();
      end
      repeat (260) step();

      // lores with D1=60 against undelayed plane 2
      mode(1'b0, 1'b0);
      wr(8'h81, 32'h000F);
      wr(8'h89, 32'hF000);
      wr(8'h88, 32'hF000);
      for (int c = 0; c < 80; c++) begin
         e = (c < 16 ? 8'h02 : 8'h00) | ((c >= 60 && c < 76) ? 8'h01 : 8'h00);
         chk($sformatf("d60_c%0d", c), ifa.bpldata_o, e);
         step();
      end
      repeat (260) step();

      // BPLCON1 cleared mid-word: tap jumps straight to the shifter MSB
      wr(8'h88, 32'hFFFF);
      for (int c = 0; c < 10; c++) begin
         chk($sformatf("retap_pre_c%0d", c), ifa.bpldata_o, 0);
         step();
      end
      wr(8'h81, 32'h0000);
      chk("retap_post", ifa.bpldata_o, 1);
      repeat (80) step();

      // plane 8 buffer, then a reload without rewriting it
      wr(8'h8F, 32'hFFFF);
      wr(8'h88, 32'h0000);
      for (int c = 0; c < 66; c++) begin
         chk($sformatf("p8_c%0d", c), ifa.bpldata_o, c < 64 ? 8'h80 : 8'h00);
         step();
      end
      wr(8'h88, 32'h0000);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("p8clr_c%0d", c), ifa.bpldata_o, 0);
         step();
      end

      // asynchronous reset mid-word, delay lines must be flushed too
      wr(8'h88, 32'hFFFF);
      repeat (20) step();
      chk("pre_reset", ifa.bpldata_o, 1);
      rst_n = 1'b0;
      #1;
      chk("async_reset", ifa.bpldata_o, 0);
      step();
      step();
      rst_n = 1'b1;
      wr(8'h81, 32'h000F);
      for (int c = 0; c < 260; c++) begin
         chk($sformatf("post_reset_c%0d", c), ifa.bpldata_o, 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
